oled_init_seq: RTL and testbench

//   Upstream command sequencer for the SPI serializer. After reset it pulses the

---
 rtl/oled_init_seq.sv | 170 +++++++++++++++++
 tb/tb_oled_init_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/oled_init_seq.sv
// SSD1306 bring-up sequencer: pulses OLED_RES, streams 25 init commands and a full-screen clear
// as {CS,DC,byte} words. One SPI_START per word; the next word waits for SPI_DONE.
module oled_init_seq #(
   parameter int RES_LOW_CYC  = 10,
   parameter int RES_WAIT_CYC = 10,
   parameter int PAGES        = 8,
   parameter int COLS         = 128
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       SPI_DONE,
   input  logic       RESTART,
   output logic       SPI_START,
   output logic [9:0] SPI_DATA,
   output logic       OLED_RES,
   output logic       READY
);

   localparam int TMAX = (RES_LOW_CYC > RES_WAIT_CYC) ? RES_LOW_CYC : RES_WAIT_CYC;
   localparam int TW   = $clog2(TMAX) + 1;
   localparam int CW   = $clog2(COLS) + 1;
   localparam int PW   = $clog2(PAGES) + 1;

   localparam logic [TW-1:0] LO_LAST   = TW'(RES_LOW_CYC - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(RES_WAIT_CYC - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
   localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
   localparam logic [4:0]    IDX_LAST  = 5'd24;

   typedef enum logic [2:0] {
      S_RES_LO, S_RES_WAIT, S_CMD_ISSUE, S_CMD_WAIT, S_CLR_ISSUE, S_CLR_WAIT, S_READY
   } state_t;

   state_t        state, state_n;
   logic [TW-1:0] cnt, cnt_n;
   logic [4:0]    idx, idx_n;
   logic [PW-1:0] page, page_n;
   logic [CW-1:0] col, col_n;
   logic [1:0]    sub, sub_n;
   logic [9:0]    clr_word;

   function automatic logic [7:0] init_rom(input logic [4:0] i);
      case (i)
         5'd0:  init_rom = 8'hAE;  5'd1:  init_rom = 8'hD5;  5'd2:  init_rom = 8'h80;
         5'd3:  init_rom = 8'hA8;  5'd4:  init_rom = 8'h3F;  5'd5:  init_rom = 8'hD3;
         5'd6:  init_rom = 8'h00;  5'd7:  init_rom = 8'h40;  5'd8:  init_rom = 8'h8D;
         5'd9:  init_rom = 8'h14;  5'd10: init_rom = 8'h20;  5'd11: init_rom = 8'h02;
         5'd12: init_rom = 8'hA1;  5'd13: init_rom = 8'hC8;  5'd14: init_rom = 8'hDA;
         5'd15: init_rom = 8'h12;  5'd16: init_rom = 8'h81;  5'd17: init_rom = 8'hCF;
         5'd18: init_rom = 8'hD9;  5'd19: init_rom = 8'hF1;  5'd20: init_rom = 8'hDB;
         5'd21: init_rom = 8'h40;  5'd22: init_rom = 8'hA4;  5'd23: init_rom = 8'hA6;
         5'd24: init_rom = 8'hAF;
         default: init_rom = 8'hE3;
      endcase
   endfunction

   // Per page: set page address, column low/high nibble to 0, then COLS zero data bytes.
   always_comb begin
      case (sub)
         2'd0:    clr_word = {2'b00, 8'hB0 + 8'(page)};
         2'd1:    clr_word = 10'h000;
         2'd2:    clr_word = 10'h010;
         default: clr_word = 10'h100;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= S_RES_LO;
         cnt   <= '0;
         idx   <= '0;
         page  <= '0;
         col   <= '0;
         sub   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         page  <= page_n;
         col   <= col_n;
         sub   <= sub_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      page_n    = page;
      col_n     = col;
      sub_n     = sub;
      SPI_START = 1'b0;
      SPI_DATA  = 10'h3FF;
      OLED_RES  = 1'b1;
      READY     = 1'b0;
      case (state)
         S_RES_LO: begin
            OLED_RES = 1'b0;
            if (cnt == LO_LAST) begin
               cnt_n   = '0;
               state_n = S_RES_WAIT;
            end else begin
               cnt_n = cnt + TW'(1);
            end
         end
         S_RES_WAIT: begin
            if (cnt == WAIT_LAST) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = S_CMD_ISSUE;
            end else begin
               cnt_n = cnt + TW'(1);
            end
         end
         S_CMD_ISSUE: begin
            SPI_DATA  = {2'b00, init_rom(idx)};
            SPI_START = 1'b1;
            state_n   = S_CMD_WAIT;
         end
         S_CMD_WAIT: begin
            SPI_DATA = {2'b00, init_rom(idx)};
            if (SPI_DONE) begin
               if (idx == IDX_LAST) begin
                  page_n  = '0;
                  col_n   = '0;
                  sub_n   = '0;
                  state_n = S_CLR_ISSUE;
               end else begin
                  idx_n   = idx + 5'd1;
                  state_n = S_CMD_ISSUE;
               end
            end
         end
         S_CLR_ISSUE: begin
            SPI_DATA  = clr_word;
            SPI_START = 1'b1;
            state_n   = S_CLR_WAIT;
         end
         S_CLR_WAIT: begin
            SPI_DATA = clr_word;
            if (SPI_DONE) begin
               state_n = S_CLR_ISSUE;
               if (sub != 2'd3) begin
                  sub_n = sub + 2'd1;
               end else if (col != COL_LAST) begin
                  col_n = col + CW'(1);
               end else begin
                  col_n = '0;
                  sub_n = '0;
                  if (page == PAGE_LAST) state_n = S_READY;
                  else                   page_n  = page + PW'(1);
               end
            end
         end
         S_READY: begin
            READY = 1'b1;
            if (RESTART) begin
               cnt_n   = '0;
               idx_n   = '0;
               page_n  = '0;
               col_n   = '0;
               sub_n   = '0;
               state_n = S_RES_LO;
            end
         end
         default: state_n = S_RES_LO;
      endcase
   end

endmodule

// File: tb/tb_oled_init_seq.sv
// Directed bench for oled_init_seq: serializer model answers SPI_DONE a fixed delay after
// each SPI_START, captures every word and compares against a bench-built expected stream.
module tb_oled_init_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_done = 1'b0;
   logic       restart;
   logic       spi_start;
   logic [9:0] spi_data;
   logic       oled_res;
   logic       ready;

   int         n_checks = 0;
   int         n_errors = 0;

   logic [9:0] words[$];
   logic [9:0] exp_words[$];
   logic [7:0] rom[25];

   int         cyc = 0;
   int         pend = 0;
   int         dly = 20;
   logic       auto_done;
   int         spur_req = 0;
   int         spur_ack = 0;
   logic       outst = 1'b0;
   logic [9:0] held = '0;
   int         viol = 0;
   int         done_cyc = 0;
   int         ready_cyc = 0;
   logic       ready_q = 1'b0;

   oled_init_seq dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .SPI_DONE (spi_done),
      .RESTART  (restart),
      .SPI_START(spi_start),
      .SPI_DATA (spi_data),
      .OLED_RES (oled_res),
      .READY    (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Serializer model and handshake monitor, all on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (ready && !ready_q) ready_cyc = cyc;
         ready_q = ready;
         if (!rst_n) begin
            pend  = 0;
            outst = 1'b0;
         end else begin
            if (spi_done) outst = 1'b0;
            if (spi_start) begin
               if (outst) viol++;
               outst = 1'b1;
               held  = spi_data;
               words.push_back(spi_data);
            end else if (outst && spi_data != held) begin
               viol++;
            end
         end
         spi_done = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               spi_done = 1'b1;
               done_cyc = cyc;
            end
         end
         if (spi_start && auto_done && rst_n) pend = dly;
         if (spur_req != spur_ack) begin
            spur_ack = spur_req;
            spi_done = 1'b1;
            done_cyc = cyc;
         end
      end
   end

   task automatic wait_ready(input int bound);
      int n = 0;
      while (!ready && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("ready_reached", {31'd0, ready}, 32'd1);
   endtask

   task automatic wait_words(input int target, input int bound);
      int n = 0;
      while (words.size() < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("words_reached", {31'd0, words.size() >= target}, 32'd1);
   endtask

   task automatic check_run(input string tag);
      int bad = 0;
      check({tag, "_count"}, words.size(), 1073);
      for (int i = 0; i < words.size() && i < exp_words.size(); i++)
         if (words[i] != exp_words[i]) bad++;
      check({tag, "_seq"}, bad, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start"}, {31'd0, spi_start}, 32'd0);
      check({tag, "_data"},  {22'd0, spi_data}, 32'h3FF);
      check({tag, "_res"},   {31'd0, oled_res}, 32'd0);
      check({tag, "_ready"}, {31'd0, ready}, 32'd0);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   initial begin
      int lo_cnt;
      int hi_cnt;
      int n_start;

      rom = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
              8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
              8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
      for (int i = 0; i < 25; i++) exp_words.push_back({2'b00, rom[i]});
      for (int p = 0; p < 8; p++) begin
         exp_words.push_back({2'b00, 8'hB0 + 8'(p)});
         exp_words.push_back(10'h000);
         exp_words.push_back(10'h010);
         for (int c = 0; c < 128; c++) exp_words.push_back(10'h100);
      end

      rst_n     = 1'b0;
      restart   = 1'b0;
      auto_done = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");

      // Run 1: reset pulse timing, spurious DONE, long DONE hold, full stream.
      rst_n  = 1'b1;
      lo_cnt = 0;
      while (!oled_res && lo_cnt < 100) begin
         lo_cnt++;
         @(negedge clk);
      end
      check("res_low_cyc", lo_cnt, 10);
      spur_req++;
      hi_cnt = 0;
      while (!spi_start && hi_cnt < 100) begin
         hi_cnt++;
         @(negedge clk);
      end
      check("res_wait_cyc", hi_cnt, 10);
      check("first_word", {22'd0, spi_data}, 32'h0AE);

      n_start = 0;
      repeat (1000) begin
         @(negedge clk);
         if (spi_start) n_start++;
      end
      check("hold_no_start", n_start, 0);
      check("hold_data", {22'd0, spi_data}, 32'h0AE);
      auto_done = 1'b1;
      spur_req++;

      wait_ready(40000);
      check_run("run1");
      check("second_word", {22'd0, words[1]}, 32'h0D5);
      check("page0_addr", {22'd0, words[25]}, 32'h0B0);
      check("page0_first_data", {22'd0, words[28]}, 32'h100);
      check("page3_addr", {22'd0, words[25 + 3 * 131]}, 32'h0B3);
      check("last_word", {22'd0, words[1072]}, 32'h100);
      check("ready_latency", ready_cyc - done_cyc, 1);
      check("idle_data", {22'd0, spi_data}, 32'h3FF);

      // Run 2: RESTART from READY, then a RESTART mid-clear that must be ignored.
      dly = 3;
      words.delete();
      pulse_restart();
      check("restart_ready", {31'd0, ready}, 32'd0);
      check("restart_res", {31'd0, oled_res}, 32'd0);
      wait_words(40, 5000);
      pulse_restart();
      check("restart_ignored_res", {31'd0, oled_res}, 32'd1);
      wait_ready(10000);
      check_run("run2");

      // Run 3: asynchronous reset during page 3 of the clear.
      words.delete();
      pulse_restart();
      wait_words(25 + 3 * 131 + 5, 10000);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (3) @(negedge clk);
      words.delete();
      rst_n = 1'b1;
      #1;
      check("rerun_res_low", {31'd0, oled_res}, 32'd0);
      wait_ready(10000);
      check_run("run3");
      check("handshake_violations", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
